// File: rtl/tinker_regfile_sb.sv
// Register file with per-register pending-write scoreboard, flush and sticky error flag.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to read ports and sp_out.
module tinker_regfile_sb #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 3,
  parameter int unsigned SP_INDEX = 31,
  parameter logic [63:0] SP_RESET = 64'd524288,
  parameter int unsigned PEND_W   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  input  logic [NUM_RD-1:0]          rd_en,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  output logic                       stall,
  input  logic                       issue_valid,
  input  logic [ADDR_W-1:0]          issue_addr,
  output logic                       issue_ready,
  input  logic                       wb_valid,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       flush,
  output logic [DATA_W-1:0]          sp_out,
  output logic                       sb_err
);

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  localparam logic [ADDR_W-1:0] SP_ADDR  = ADDR_W'(SP_INDEX);
  localparam logic [DATA_W-1:0] SP_INIT  = DATA_W'(SP_RESET);

  if (ADDR_W != $clog2(NUM_REGS)) begin : g_bad_addr_w
    $error("ADDR_W must equal log2(NUM_REGS)");
  end
  if (SP_INDEX >= NUM_REGS) begin : g_bad_sp
    $error("SP_INDEX out of range");
  end

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [PEND_W-1:0] cnt_q  [NUM_REGS];
  logic [PEND_W-1:0] cnt_d  [NUM_REGS];
  logic [NUM_REGS-1:0] inc_sel;
  logic [NUM_REGS-1:0] dec_sel;
  logic sb_err_q;
  logic sb_err_d;
  logic issue_acc;
  logic wb_same;
  logic [NUM_RD-1:0] rd_stall;

  // An issue dropped by flush still counts as refused for the counters.
  assign issue_ready = (cnt_q[issue_addr] != PEND_MAX);
  assign issue_acc   = issue_valid & issue_ready & ~flush;
  assign wb_same     = issue_acc & wb_valid & (issue_addr == wb_addr);

  // Register storage: write-back lands regardless of scoreboard state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= (i == int'(SP_INDEX)) ? SP_INIT : '0;
      end
    end else if (wb_valid) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // Next pending counts; flush dominates, matched issue+wb cancels out.
  always_comb begin
    inc_sel  = '0;
    dec_sel  = '0;
    sb_err_d = sb_err_q;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      cnt_d[i]   = cnt_q[i];
      inc_sel[i] = issue_acc && (issue_addr == ADDR_W'(i));
      dec_sel[i] = wb_valid && (wb_addr == ADDR_W'(i));
      if (flush) begin
        cnt_d[i] = '0;
      end else if (inc_sel[i] && !dec_sel[i]) begin
        cnt_d[i] = cnt_q[i] + PEND_ONE;
      end else if (dec_sel[i] && !inc_sel[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - PEND_ONE;
      end
    end
    if (wb_valid && !flush && !wb_same && (cnt_q[wb_addr] == '0)) begin
      sb_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        cnt_q[i] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      sb_err_q <= sb_err_d;
    end
  end

  assign sb_err = sb_err_q;

  // Read ports, busy flags and per-port stall contribution.
  for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [PEND_W-1:0] rcnt;
    assign ra   = rd_addr[p*ADDR_W +: ADDR_W];
    assign rcnt = cnt_q[ra];
`ifdef REGFILE_BYPASS_EN
    logic wb_hit;
    assign wb_hit = wb_valid && (wb_addr == ra);
    assign rd_data[p*DATA_W +: DATA_W] = wb_hit ? wb_data : regs_q[ra];
    assign rd_busy[p] = (rcnt != '0) && !(wb_hit && (rcnt == PEND_ONE));
`else
    assign rd_data[p*DATA_W +: DATA_W] = regs_q[ra];
    assign rd_busy[p] = (rcnt != '0);
`endif
    assign rd_stall[p] = rd_en[p] & rd_busy[p];
  end

`ifdef REGFILE_BYPASS_EN
  assign sp_out = (wb_valid && (wb_addr == SP_ADDR)) ? wb_data : regs_q[SP_INDEX];
`else
  assign sp_out = regs_q[SP_INDEX];
`endif

  assign stall = (|rd_stall) | (issue_valid & ~issue_ready);

endmodule
